// File: rtl/dm_mem_unit.sv
// dm_mem_unit: latency-configurable byte/half/word data memory with alignment and range exceptions.
// Define DM_STORE_TRACE_EN to print every committed store.
module dm_mem_unit #(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  width,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        exc_adel,
    output logic        exc_ades
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    state_t state;
    logic [3:0] cnt;
    logic we_q;
    logic [2:0] width_q;
    logic [31:0] addr_q, wdata_q, pc_q;
    logic [31:0] mem [DEPTH];
    logic [32:0] off;
    logic half, half_q, exc;
    logic [ADDR_WIDTH-1:0] idx;
    logic [31:0] cur, wrep, merged, load_val;
    logic [3:0] mask;
    logic [15:0] sh;
    assign off = {1'b0, addr} - {1'b0, BASE_ADDR};
    assign half = width == 3'd1 || width == 3'd2;
    assign exc = width > 3'd4 || (half && addr[0]) || (width == 3'd0 && addr[1:0] != 2'b00)
                 || off >= (33'd1 << (ADDR_WIDTH + 2));
    assign half_q = width_q == 3'd1 || width_q == 3'd2;
    assign idx = ADDR_WIDTH'((addr_q - BASE_ADDR) >> 2);
    assign cur = mem[idx];
    assign mask = width_q == 3'd0 ? 4'hF : half_q ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b0001 << addr_q[1:0];
    assign wrep = width_q == 3'd0 ? wdata_q : half_q ? {2{wdata_q[15:0]}} : {4{wdata_q[7:0]}};
    // Lanes not covered by the mask keep the current word contents.
    always_comb begin
        merged = cur;
        for (int i = 0; i < 4; i++)
            if (mask[i]) merged[8*i +: 8] = wrep[8*i +: 8];
    end
    assign sh = 16'(cur >> {addr_q[1:0], 3'b000});
    assign load_val = width_q == 3'd1 ? {{16{sh[15]}}, sh} :
                      width_q == 3'd2 ? {16'h0, sh} :
                      width_q == 3'd3 ? {{24{sh[7]}}, sh[7:0]} :
                      width_q == 3'd4 ? {24'h0, sh[7:0]} : cur;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt <= 4'd0;
            ready <= 1'b0;
            busy <= 1'b0;
            rdata <= 32'h0;
            exc_adel <= 1'b0;
            exc_ades <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
        end else begin
            ready <= 1'b0;
            case (state)
                IDLE: if (req) begin
                    we_q <= we;
                    width_q <= width;
                    addr_q <= addr;
                    wdata_q <= wdata;
                    pc_q <= pc;
                    busy <= 1'b1;
                    exc_adel <= exc && !we;
                    exc_ades <= exc && we;
                    state <= exc ? DONE : WAIT;
                    ready <= exc;
                    cnt <= 4'(LATENCY - 1);
                end
                WAIT: if (cnt != 4'd0) cnt <= cnt - 4'd1;
                else begin
                    state <= DONE;
                    ready <= 1'b1;
                    if (we_q) mem[idx] <= merged;
                    else rdata <= load_val;
`ifdef DM_STORE_TRACE_EN
                    if (we_q) $display("@%h: *%h <= %h", pc_q, {addr_q[31:2], 2'b00}, merged);
`endif
                end
                default: begin
                    state <= IDLE;
                    busy <= 1'b0;
                end
            endcase
        end
    end
`ifndef DM_STORE_TRACE_EN
    logic unused_pc;
    assign unused_pc = ^pc_q;
`endif
endmodule
